// File: rtl/flex_reg_bank.sv
// Primary-bus register bank with a per-register mode (RW, RO, PULSE, W1C),
// per-register write strobes and an aggregated sticky-event interrupt.
module flex_reg_bank #(
  parameter int addr_bus_width = 16,
  parameter int data_bus_width = 16,
  parameter logic [addr_bus_width-1:0] base_addr = '0,
  parameter int nr_registers = 4,
  parameter logic [2*nr_registers-1:0] reg_mode = '0,
  parameter logic [nr_registers*data_bus_width-1:0] reset_value = '0,
  parameter int sync_stages = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [addr_bus_width-1:0]              addr,
  input  logic [data_bus_width-1:0]              data_w,
  input  logic                                   addr_strobe,
  input  logic                                   read_trg,
  input  logic                                   write_trg,
  output logic [data_bus_width-1:0]              data_r,
  output logic                                   data_r_act,
  output logic                                   dtack,
  input  logic [nr_registers*data_bus_width-1:0] in_bits,
  output logic [nr_registers*data_bus_width-1:0] bits,
  output logic [nr_registers-1:0]                wr_strobe,
  output logic                                   irq
);

  localparam int DW = data_bus_width;
  localparam int N  = nr_registers;
  localparam int S  = (N > 1) ? $clog2(N) : 0;
  localparam int SW = (S > 0) ? S : 1;

  typedef enum logic [1:0] {M_RW, M_RO, M_PULSE, M_W1C} mode_t;
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  logic [DW-1:0]       r_reg [N];
  logic [N*DW-1:0]     r_sync [sync_stages];
  logic [N*DW-1:0]     r_prev;
  logic [DW-1:0]       r_data_r;
  logic                r_dtack;
  logic                r_act;
  logic [N-1:0]        r_wr_strobe;
  logic                r_irq;

  logic [N*DW-1:0]     w_synced;
  logic [N*DW-1:0]     w_rise;
  logic [SW-1:0]       w_sel;
  logic                w_hit;
  logic                w_valid;
  logic                w_acc;
  logic                w_rd;
  logic                w_wr;
  logic [N-1:0]        w_wr_vec;
  logic [DW-1:0]       w_rdata;
  logic                w_w1c_any;

  assign w_synced = r_sync[sync_stages-1];
  assign w_rise   = w_synced & ~r_prev;

  // With a single register there are no select bits; register 0 is implied.
  assign w_sel   = (S == 0) ? '0 : addr[SW-1:0];
  assign w_hit   = addr_strobe && ((addr >> S) == (base_addr >> S));
  assign w_valid = 32'(w_sel) < 32'(N);
  assign w_acc   = (r_state == S_IDLE) && w_hit && w_valid;
  assign w_rd    = w_acc && read_trg;
  assign w_wr    = w_acc && write_trg && !read_trg;

  always_comb begin
    w_wr_vec  = '0;
    w_rdata   = '0;
    w_w1c_any = 1'b0;
    bits      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_wr_vec[i]      = w_wr && (32'(w_sel) == i);
      bits[i*DW +: DW] = r_reg[i];
      if (mode_t'(reg_mode[2*i +: 2]) == M_W1C)
        w_w1c_any = w_w1c_any | (|r_reg[i]);
      if (32'(w_sel) == i) begin
        case (mode_t'(reg_mode[2*i +: 2]))
          M_RO:    w_rdata = w_synced[i*DW +: DW];
          M_PULSE: w_rdata = '0;
          default: w_rdata = r_reg[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < sync_stages; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_bits;
      for (int unsigned s = 1; s < sync_stages; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= w_synced;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++)
        r_reg[i] <= (mode_t'(reg_mode[2*i +: 2]) == M_RW) ? reset_value[i*DW +: DW] : '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        case (mode_t'(reg_mode[2*i +: 2]))
          M_RW:    if (w_wr_vec[i]) r_reg[i] <= data_w;
          M_RO:    r_reg[i] <= '0;
          M_PULSE: r_reg[i] <= w_wr_vec[i] ? data_w : '0;
          // Set is OR-ed in after the clear so a same-cycle edge wins.
          default: r_reg[i] <= (r_reg[i] & ~(w_wr_vec[i] ? data_w : '0))
                               | w_rise[i*DW +: DW];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data_r    <= '0;
      r_dtack     <= 1'b0;
      r_act       <= 1'b0;
      r_wr_strobe <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_wr_strobe <= w_wr_vec;
      r_irq       <= w_w1c_any;
      case (r_state)
        S_IDLE: begin
          if (w_rd) begin
            r_data_r <= w_rdata;
            r_dtack  <= 1'b1;
            r_act    <= 1'b1;
            r_state  <= S_WAIT;
          end else if (w_wr) begin
            r_dtack  <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if ((!read_trg && !write_trg) || !w_hit) begin
            r_dtack <= 1'b0;
            r_act   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_r     = r_data_r;
  assign data_r_act = r_act;
  assign dtack      = r_dtack;
  assign wr_strobe  = r_wr_strobe;
  assign irq        = r_irq;

endmodule

// File: tb/tb_flex_reg_bank.sv
// Directed bench for flex_reg_bank: N=4, modes {RW,RO,PULSE,W1C}, base 0x0040.
module tb_flex_reg_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] data_w;
  logic        addr_strobe;
  logic        read_trg;
  logic        write_trg;
  logic [15:0] data_r;
  logic        data_r_act;
  logic        dtack;
  logic [63:0] in_bits;
  logic [63:0] bits;
  logic [3:0]  wr_strobe;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  flex_reg_bank #(
    .addr_bus_width(16),
    .data_bus_width(16),
    .base_addr     (16'h0040),
    .nr_registers  (4),
    .reg_mode      (8'b11_10_01_00),
    .reset_value   (64'h0000_0000_0000_A5A5),
    .sync_stages   (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .data_w     (data_w),
    .addr_strobe(addr_strobe),
    .read_trg   (read_trg),
    .write_trg  (write_trg),
    .data_r     (data_r),
    .data_r_act (data_r_act),
    .dtack      (dtack),
    .in_bits    (in_bits),
    .bits       (bits),
    .wr_strobe  (wr_strobe),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] b0;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] d, input logic ack,
                              input logic [15:0] rdata, input logic [15:0] b0);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.ack = ack; v.rdata = rdata; v.b0 = b0;
    return v;
  endfunction

  // Called just after a negedge; drives the request, samples one clock later,
  // releases the request and samples again one clock after that.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, output logic ack, output logic act,
                           output logic [15:0] rdat, output logic [3:0] strb,
                           output logic late);
    addr = a; data_w = d; addr_strobe = 1'b1; read_trg = rd; write_trg = wr;
    @(negedge clock);
    ack = dtack; act = data_r_act; rdat = data_r; strb = wr_strobe;
    read_trg = 1'b0; write_trg = 1'b0; addr_strobe = 1'b0;
    @(negedge clock);
    late = dtack | data_r_act | (|wr_strobe);
  endtask

  initial begin
    logic        ack, act, late;
    logic [15:0] rdat;
    logic [3:0]  strb;
    logic [3:0]  exp_strb;

    vecs[0] = mk(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hA5A5, 16'hA5A5);
    vecs[1] = mk(1'b0, 1'b1, 16'h0040, 16'h1234, 1'b1, 16'h0000, 16'h1234);
    vecs[2] = mk(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h1234, 16'h1234);
    vecs[3] = mk(1'b0, 1'b1, 16'h0044, 16'hBEEF, 1'b0, 16'h0000, 16'h1234);
    vecs[4] = mk(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 16'h00F0, 16'h1234);
    vecs[5] = mk(1'b0, 1'b1, 16'h0041, 16'hFFFF, 1'b1, 16'h0000, 16'h1234);
    vecs[6] = mk(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 16'h00F0, 16'h1234);
    vecs[7] = mk(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b1, 16'h0000, 16'h1234);
    vecs[8] = mk(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h1234, 16'h1234);
    vecs[9] = mk(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h1234);

    reset = 1'b1; addr = '0; data_w = '0; addr_strobe = 1'b0;
    read_trg = 1'b0; write_trg = 1'b0;
    in_bits = 64'h0000_0000_00F0_0000;
    repeat (2) @(negedge clock);
    chk("rst_dtack", 64'(dtack), 64'h0);
    chk("rst_act", 64'(data_r_act), 64'h0);
    chk("rst_data_r", 64'(data_r), 64'h0);
    chk("rst_bits", bits, 64'h0000_0000_0000_A5A5);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_strobe", 64'(wr_strobe), 64'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, ack, act, rdat, strb, late);
      exp_strb = (vecs[i].wr && !vecs[i].rd && vecs[i].ack) ? (4'b0001 << vecs[i].a[1:0]) : 4'b0000;
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(vecs[i].ack));
      chk($sformatf("v%0d_act", i), 64'(act), 64'(vecs[i].rd && vecs[i].ack));
      if (vecs[i].rd && vecs[i].ack)
        chk($sformatf("v%0d_rdata", i), 64'(rdat), 64'(vecs[i].rdata));
      chk($sformatf("v%0d_strobe", i), 64'(strb), 64'(exp_strb));
      chk($sformatf("v%0d_release", i), 64'(late), 64'h0);
      chk($sformatf("v%0d_bits0", i), 64'(bits[15:0]), 64'(vecs[i].b0));
    end

    // PULSE: exactly one clock of data on bits[47:32]
    addr = 16'h0042; data_w = 16'h8001; addr_strobe = 1'b1; write_trg = 1'b1;
    @(negedge clock);
    chk("pulse_on", 64'(bits[47:32]), 64'h8001);
    chk("pulse_strobe", 64'(wr_strobe), 64'h4);
    chk("pulse_ack", 64'(dtack), 64'h1);
    write_trg = 1'b0; addr_strobe = 1'b0;
    @(negedge clock);
    chk("pulse_off", 64'(bits[47:32]), 64'h0);
    @(negedge clock);
    chk("pulse_stays_off", 64'(bits[47:32]), 64'h0);

    // W1C: set via synchronised rising edge, irq one clock later
    in_bits[63:48] = 16'h0003;
    repeat (2) @(negedge clock);
    chk("w1c_not_yet", 64'(bits[63:48]), 64'h0);
    @(negedge clock);
    chk("w1c_set", 64'(bits[63:48]), 64'h3);
    chk("w1c_irq_lag", 64'(irq), 64'h0);
    @(negedge clock);
    chk("w1c_irq", 64'(irq), 64'h1);
    do_access(1'b1, 1'b0, 16'h0043, 16'h0000, ack, act, rdat, strb, late);
    chk("w1c_read", 64'(rdat), 64'h3);
    do_access(1'b0, 1'b1, 16'h0043, 16'h0001, ack, act, rdat, strb, late);
    chk("w1c_clr0", 64'(bits[63:48]), 64'h2);
    chk("w1c_clr0_strobe", 64'(strb), 64'h8);
    chk("w1c_irq_held", 64'(irq), 64'h1);

    in_bits[63:48] = 16'h0001;
    repeat (4) @(negedge clock);
    in_bits[63:48] = 16'h0003;
    repeat (2) @(negedge clock);
    do_access(1'b0, 1'b1, 16'h0043, 16'h0002, ack, act, rdat, strb, late);
    chk("w1c_set_wins", 64'(bits[63:48]), 64'h2);
    do_access(1'b0, 1'b1, 16'h0043, 16'h0002, ack, act, rdat, strb, late);
    chk("w1c_clr1", 64'(bits[63:48]), 64'h0);
    chk("w1c_irq_clr", 64'(irq), 64'h0);

    // Reset during WAIT with read_trg held
    addr = 16'h0040; addr_strobe = 1'b1; read_trg = 1'b1;
    @(negedge clock);
    chk("mid_ack", 64'(dtack), 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_dtack", 64'(dtack), 64'h0);
    chk("mid_rst_act", 64'(data_r_act), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ack", 64'(dtack), 64'h1);
    chk("post_rst_data", 64'(data_r), 64'hA5A5);
    read_trg = 1'b0; addr_strobe = 1'b0;
    @(negedge clock);
    chk("post_rst_drop", 64'(dtack), 64'h0);

    // Read and write together: read wins, register untouched
    do_access(1'b1, 1'b1, 16'h0040, 16'h5555, ack, act, rdat, strb, late);
    chk("rw_ack", 64'(ack), 64'h1);
    chk("rw_data", 64'(rdat), 64'hA5A5);
    chk("rw_strobe", 64'(strb), 64'h0);
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, ack, act, rdat, strb, late);
    chk("rw_readback", 64'(rdat), 64'hA5A5);
    chk("rw_bits0", 64'(bits[15:0]), 64'hA5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
